// File: rtl/proc_pkg.sv
// Shared types and helpers for the four-way round-robin write-port arbiter.
package proc_pkg;

  localparam int NREQ = 4;
  localparam int DW   = 16;

  typedef enum logic {
    IDLE,
    GRANT
  } arb_state_e;

  // Returns {found, idx}: the first requester at or after ptr (mod 4) with req set.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

endpackage

// File: rtl/mult4_2.sv
// Team 4:1 selector; num picks one of in_1..in_4 onto out.
module mult4_2 #(
  parameter int W = 16
) (
  input  logic [1:0]   num,
  input  logic [W-1:0] in_1,
  input  logic [W-1:0] in_2,
  input  logic [W-1:0] in_3,
  input  logic [W-1:0] in_4,
  output logic [W-1:0] out
);

  always_comb begin
    out = in_1;
    case (num)
      2'd0: out = in_1;
      2'd1: out = in_2;
      2'd2: out = in_3;
      2'd3: out = in_4;
      default: out = in_1;
    endcase
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 16-bit write port among four requesters;
// control lives here, the data word is routed through mult4_2.
module mux4_rr_arbiter
  import proc_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    req,
  input  logic [DW-1:0] data_0,
  input  logic [DW-1:0] data_1,
  input  logic [DW-1:0] data_2,
  input  logic [DW-1:0] data_3,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic [1:0]    sel,
  output logic [3:0]    gnt,
  output logic [3:0]    ack
);

  arb_state_e state;
  logic [1:0] ptr;
  logic       xfer;
  logic [2:0] pick_idle;
  logic [2:0] pick_next;

  // Gating with rst_n keeps a word presented during reset from being taken or acked.
  assign out_valid = rst_n && (state == GRANT) && req[sel];
  assign xfer      = out_valid && out_ready;
  assign ack       = xfer ? (4'b0001 << sel) : 4'b0000;

  // The post-transfer pick already uses the advanced pointer, so a waiting
  // requester is granted without a bubble.
  assign pick_idle = rr_pick(req, ptr);
  assign pick_next = rr_pick(req & ~(4'b0001 << sel), sel + 2'd1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= 2'd0;
      gnt   <= 4'b0000;
      sel   <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_idle[2]) begin
            state <= GRANT;
            sel   <= pick_idle[1:0];
            gnt   <= 4'b0001 << pick_idle[1:0];
          end
        end
        GRANT: begin
          if (xfer) begin
            ptr <= sel + 2'd1;
            if (pick_next[2]) begin
              sel <= pick_next[1:0];
              gnt <= 4'b0001 << pick_next[1:0];
            end else begin
              state <= IDLE;
              gnt   <= 4'b0000;
            end
          end else if (!req[sel]) begin
            state <= IDLE;
            gnt   <= 4'b0000;
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= 4'b0000;
        end
      endcase
    end
  end

  mult4_2 #(.W(DW)) u_mux (
    .num  (sel),
    .in_1 (data_0),
    .in_2 (data_1),
    .in_3 (data_2),
    .in_4 (data_3),
    .out  (out_data)
  );

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench for mux4_rr_arbiter: directed scenarios then random traffic.
module tb_mux4_rr_arbiter;
  import proc_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    req = 4'b0000;
  logic [DW-1:0] data_0 = '0;
  logic [DW-1:0] data_1 = '0;
  logic [DW-1:0] data_2 = '0;
  logic [DW-1:0] data_3 = '0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [1:0]    sel;
  logic [3:0]    gnt;
  logic [3:0]    ack;

  mux4_rr_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .data_0    (data_0),
    .data_1    (data_1),
    .data_2    (data_2),
    .data_3    (data_3),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .sel       (sel),
    .gnt       (gnt),
    .ack       (ack)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  sel;
    logic [15:0] data;
  } xfer_t;

  // mask bits: 0 out_valid, 1 sel, 2 gnt, 3 out_data, 4 ack
  typedef struct packed {
    int          cyc;
    int          id;
    logic [4:0]  mask;
    logic        vld;
    logic [1:0]  sel;
    logic [3:0]  gnt;
    logic [15:0] data;
    logic [3:0]  ack;
  } dchk_t;

  xfer_t sb[$];
  dchk_t dq[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int    vecs = 0;
  int    errs = 0;
  bit    done = 1'b0;
  int    nid = 0;
  dchk_t d;
  xfer_t x;

  bit          m_busy = 1'b0;
  int          m_sel = 0;
  int          m_ptr = 0;
  logic        pend[4];
  logic [15:0] wdata[4];

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s #%0d at cycle %0d: got %h expected %h", name, id, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    while (dq.size() > 0 && dq[0].cyc == cyc) begin
      d = dq.pop_front();
      if (d.mask[0]) chk("out_valid", d.id, 32'(out_valid), 32'(d.vld));
      if (d.mask[1]) chk("sel", d.id, 32'(sel), 32'(d.sel));
      if (d.mask[2]) chk("gnt", d.id, 32'(gnt), 32'(d.gnt));
      if (d.mask[3]) chk("out_data", d.id, 32'(out_data), 32'(d.data));
      if (d.mask[4]) chk("ack", d.id, 32'(ack), 32'(d.ack));
    end
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_transfer", cyc, 32'(sel), 32'hFFFF_FFFF);
      end else begin
        x = sb.pop_front();
        chk("xfer_sel", cyc, 32'(sel), 32'(x.sel));
        chk("xfer_data", cyc, 32'(out_data), 32'(x.data));
        chk("xfer_ack", cyc, 32'(ack), 32'(4'b0001 << x.sel));
        chk("xfer_gnt", cyc, 32'(gnt), 32'(4'b0001 << x.sel));
      end
    end else begin
      chk("ack_outside_transfer", cyc, 32'(ack), 32'd0);
    end
    if (done) begin
      chk("expected_transfers_left", 0, 32'(sb.size()), 32'd0);
      chk("directed_checks_left", 0, 32'(dq.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
    end
  end

  function automatic int pick(input logic [3:0] r, input int start);
    for (int k = 0; k < 4; k++) begin
      if (r[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  task automatic ex(input logic [4:0] m, input logic v, input int s, input logic [3:0] g,
                    input logic [15:0] dat, input logic [3:0] a);
    dq.push_back('{cyc, nid, m, v, 2'(s), g, dat, a});
    nid++;
  endtask

  // Drives one cycle of inputs and advances the reference model by one edge.
  task automatic cycle(input logic rdy, input logic rn);
    logic [3:0] r;
    int         xi;
    int         p;
    xi = -1;
    for (int i = 0; i < 4; i++) r[i] = pend[i];
    req = r;
    data_0 = wdata[0];
    data_1 = wdata[1];
    data_2 = wdata[2];
    data_3 = wdata[3];
    out_ready = rdy;
    rst_n = rn;
    if (!rn) begin
      m_busy = 1'b0;
      m_ptr = 0;
    end else if (m_busy) begin
      if (!r[m_sel]) begin
        m_busy = 1'b0;
      end else if (rdy) begin
        sb.push_back('{2'(m_sel), wdata[m_sel]});
        xi = m_sel;
        m_ptr = (m_sel + 1) % 4;
        r[m_sel] = 1'b0;
        p = pick(r, m_ptr);
        m_busy = (p >= 0);
        if (p >= 0) m_sel = p;
      end
    end else begin
      p = pick(r, m_ptr);
      if (p >= 0) begin
        m_busy = 1'b1;
        m_sel = p;
      end
    end
    @(posedge clk);
    #1;
    if (xi >= 0) pend[xi] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected summary");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      pend[i] = 1'b1;
      wdata[i] = 16'h1000 + 16'(i);
    end
    @(posedge clk);
    #1;

    // reset with all requests pending, then rotation starting at requester 0
    ex(5'b10001, 1'b0, 0, 4'b0000, 16'h0, 4'b0000); cycle(1'b1, 1'b0);
    ex(5'b10111, 1'b0, 0, 4'b0000, 16'h0, 4'b0000); cycle(1'b1, 1'b0);
    ex(5'b00101, 1'b0, 0, 4'b0000, 16'h0, 4'b0000); cycle(1'b1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      ex(5'b11111, 1'b1, k % 4, 4'(1 << (k % 4)), 16'h1000 + 16'(k % 4), 4'(1 << (k % 4)));
      cycle(1'b1, 1'b1);
      for (int i = 0; i < 4; i++) pend[i] = 1'b1;
    end
    for (int i = 0; i < 4; i++) pend[i] = 1'b0;
    ex(5'b10001, 1'b0, 0, 4'b0000, 16'h0, 4'b0000); cycle(1'b1, 1'b1);

    // single request from requester 2
    pend[2] = 1'b1;
    wdata[2] = 16'hBEEF;
    ex(5'b00101, 1'b0, 0, 4'b0000, 16'h0, 4'b0000); cycle(1'b1, 1'b1);
    ex(5'b11111, 1'b1, 2, 4'b0100, 16'hBEEF, 4'b0100); cycle(1'b1, 1'b1);

    // grant to 3 (pointer is 3), then withdrawal under backpressure
    pend[3] = 1'b1;
    wdata[3] = 16'h3333;
    ex(5'b00101, 1'b0, 0, 4'b0000, 16'h0, 4'b0000); cycle(1'b0, 1'b1);
    ex(5'b11111, 1'b1, 3, 4'b1000, 16'h3333, 4'b0000); cycle(1'b0, 1'b1);
    pend[3] = 1'b0;
    ex(5'b10101, 1'b0, 0, 4'b1000, 16'h0, 4'b0000); cycle(1'b0, 1'b1);

    // backpressure: pointer still 3, so 0 beats 1
    pend[0] = 1'b1;
    wdata[0] = 16'hAAAA;
    pend[1] = 1'b1;
    wdata[1] = 16'h5555;
    ex(5'b00101, 1'b0, 0, 4'b0000, 16'h0, 4'b0000); cycle(1'b0, 1'b1);
    repeat (5) begin
      ex(5'b11111, 1'b1, 0, 4'b0001, 16'hAAAA, 4'b0000); cycle(1'b0, 1'b1);
    end
    ex(5'b11111, 1'b1, 0, 4'b0001, 16'hAAAA, 4'b0001); cycle(1'b1, 1'b1);
    ex(5'b11111, 1'b1, 1, 4'b0010, 16'h5555, 4'b0000); cycle(1'b0, 1'b1);

    // reset during a would-be transfer; afterwards the pointer is back at 0
    pend[0] = 1'b1;
    wdata[0] = 16'h0F0F;
    ex(5'b10001, 1'b0, 0, 4'b0000, 16'h0, 4'b0000); cycle(1'b1, 1'b0);
    ex(5'b10101, 1'b0, 0, 4'b0000, 16'h0, 4'b0000); cycle(1'b1, 1'b1);
    ex(5'b11111, 1'b1, 0, 4'b0001, 16'h0F0F, 4'b0001); cycle(1'b1, 1'b1);

    // random traffic with occasional withdrawal and reset
    repeat (3000) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend[i]) begin
          if ($urandom_range(3) == 0) begin
            pend[i] = 1'b1;
            wdata[i] = 16'($urandom);
          end
        end else if ($urandom_range(31) == 0) begin
          pend[i] = 1'b0;
        end
      end
      cycle($urandom_range(3) != 0, $urandom_range(199) != 0);
    end

    for (int i = 0; i < 4; i++) pend[i] = 1'b0;
    repeat (4) cycle(1'b1, 1'b1);
    done = 1'b1;
    repeat (4) @(posedge clk);
    $display("FAIL summary_reached: got no summary expected summary line");
    $fatal(1);
  end

endmodule
